// File: rtl/cnn_pkg.sv
// Constants shared by the conved-memory writer and reader sides of the CNN datapath,
// including the reader FSM state encoding.
package cnn_pkg;

  localparam int CON_SIZE = 4;
  localparam int CON_ADDR = 2;
  localparam int DATA_W   = 16;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_LAST = 3'd2;
  localparam logic [2:0] ST_OUT  = 3'd3;
  localparam logic [2:0] ST_FIN  = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    RD   = ST_RD,
    LAST = ST_LAST,
    OUT  = ST_OUT,
    FIN  = ST_FIN
  } pool_state_t;

endpackage

// File: rtl/conved_pool_reader_if.sv
// Conved-memory read port plus the pooled-result valid/ready port of the pool reader.
interface conved_pool_reader_if
  import cnn_pkg::*;
#(
  parameter int CON_ADDR  = cnn_pkg::CON_ADDR,
  parameter int POOL_ADDR = 1,
  parameter int DATA_W    = cnn_pkg::DATA_W
);

  logic                 rd_en;
  logic [CON_ADDR-1:0]  rd_row;
  logic [CON_ADDR-1:0]  rd_col;
  logic [DATA_W-1:0]    rd_data;
  logic                 pool_valid;
  logic                 pool_ready;
  logic [DATA_W-1:0]    pool_data;
  logic [POOL_ADDR-1:0] pool_row;
  logic [POOL_ADDR-1:0] pool_col;

  modport master (
    output rd_en, rd_row, rd_col, pool_valid, pool_data, pool_row, pool_col,
    input  rd_data, pool_ready
  );

  modport slave (
    input  rd_en, rd_row, rd_col, pool_valid, pool_data, pool_row, pool_col,
    output rd_data, pool_ready
  );

endinterface

// File: rtl/pool_max_acc.sv
// Signed running maximum: load takes din unconditionally, otherwise din replaces the
// held value only when strictly greater, so ties keep the earlier pixel.
module pool_max_acc
  import cnn_pkg::*;
#(
  parameter int DATA_W = cnn_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] din,
  output logic signed [DATA_W-1:0] max
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max <= '0;
    end else if (en && (load || (din > max))) begin
      max <= din;
    end
  end

endmodule

// File: rtl/conved_pool_reader.sv
// Walks the stored conved map in POOL x POOL windows, reads each pixel once, and
// hands one signed max per window to the next layer over a valid/ready port.
module conved_pool_reader
  import cnn_pkg::*;
#(
  parameter int CON_SIZE  = cnn_pkg::CON_SIZE,
  parameter int CON_ADDR  = cnn_pkg::CON_ADDR,
  parameter int POOL      = 2,
  parameter int POOL_ADDR = 1,
  parameter int DATA_W    = cnn_pkg::DATA_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 cv_write_en,
  output logic                 busy,
  output logic                 done,
  conved_pool_reader_if.master bus
);

  localparam int                   N        = CON_SIZE / POOL;
  localparam logic [CON_ADDR-1:0]  PIX_LAST = CON_ADDR'(POOL - 1);
  localparam logic [POOL_ADDR-1:0] WIN_LAST = POOL_ADDR'(N - 1);

  pool_state_t state, next_state;

  logic [POOL_ADDR-1:0]     win_row, win_col;
  logic [CON_ADDR-1:0]      pix_row, pix_col;
  logic                     launch, rd_issue, win_accept;
  logic                     pix_first, pix_last, win_last;
  logic                     cap_pending, cap_first;
  logic signed [DATA_W-1:0] acc_max;

  assign launch    = (state == IDLE) && start && !cv_write_en;
  assign pix_first = (pix_row == '0) && (pix_col == '0);
  assign pix_last  = (pix_row == PIX_LAST) && (pix_col == PIX_LAST);
  assign win_last  = (win_row == WIN_LAST) && (win_col == WIN_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state     = state;
    rd_issue       = 1'b0;
    win_accept     = 1'b0;
    bus.pool_valid = 1'b0;
    done           = 1'b0;
    case (state)
      IDLE: if (launch) next_state = RD;
      RD: begin
        if (!cv_write_en) begin
          rd_issue = 1'b1;
          if (pix_last) next_state = LAST;
        end
      end
      LAST: next_state = OUT;
      OUT: begin
        bus.pool_valid = 1'b1;
        if (bus.pool_ready) begin
          win_accept = 1'b1;
          next_state = win_last ? FIN : RD;
        end
      end
      FIN: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Counters only move on an issued read or an accepted result, so a writer stall
  // freezes the address while the capture of the previous read still lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_row     <= '0;
      win_col     <= '0;
      pix_row     <= '0;
      pix_col     <= '0;
      busy        <= 1'b0;
      cap_pending <= 1'b0;
      cap_first   <= 1'b0;
    end else begin
      if (launch) begin
        win_row <= '0;
        win_col <= '0;
        pix_row <= '0;
        pix_col <= '0;
        busy    <= 1'b1;
      end else if (state == FIN) begin
        busy <= 1'b0;
      end
      if (rd_issue) begin
        if (pix_col == PIX_LAST) begin
          pix_col <= '0;
          pix_row <= (pix_row == PIX_LAST) ? '0 : pix_row + 1'b1;
        end else begin
          pix_col <= pix_col + 1'b1;
        end
      end
      if (win_accept) begin
        if (win_col == WIN_LAST) begin
          win_col <= '0;
          win_row <= (win_row == WIN_LAST) ? '0 : win_row + 1'b1;
        end else begin
          win_col <= win_col + 1'b1;
        end
      end
      cap_pending <= rd_issue;
      cap_first   <= rd_issue && pix_first;
    end
  end

  // Products are formed one bit wider than the address so the last window cannot overflow.
  assign bus.rd_en  = rd_issue;
  assign bus.rd_row = CON_ADDR'((CON_ADDR+1)'(win_row) * (CON_ADDR+1)'(POOL) + (CON_ADDR+1)'(pix_row));
  assign bus.rd_col = CON_ADDR'((CON_ADDR+1)'(win_col) * (CON_ADDR+1)'(POOL) + (CON_ADDR+1)'(pix_col));

  pool_max_acc #(
    .DATA_W (DATA_W)
  ) u_acc (
    .clk   (clk),
    .reset (reset),
    .load  (cap_first),
    .en    (cap_pending),
    .din   ($signed(bus.rd_data)),
    .max   (acc_max)
  );

  assign bus.pool_data = acc_max;
  assign bus.pool_row  = win_row;
  assign bus.pool_col  = win_col;

endmodule

// File: tb/tb_conved_pool_reader.sv
// Directed bench for conved_pool_reader: table of per-window expected maxima for four
// maps, plus hand-written sequences for back-pressure, writer stalls, stray starts and reset abort.
module tb_conved_pool_reader;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic cv_write_en = 1'b0;
  logic busy, done;

  always #5 clk = ~clk;

  conved_pool_reader_if #(.CON_ADDR(2), .POOL_ADDR(1), .DATA_W(16)) bus ();

  conved_pool_reader #(
    .CON_SIZE(4), .CON_ADDR(2), .POOL(2), .POOL_ADDR(1), .DATA_W(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .cv_write_en (cv_write_en),
    .busy        (busy),
    .done        (done),
    .bus         (bus.master)
  );

  typedef struct {
    int kind;
    int widx;
    int exp_data;
    int exp_row;
    int exp_col;
  } vec_t;

  typedef struct {
    int data;
    int row;
    int col;
  } res_t;

  vec_t               vecs [16];
  res_t               results [$];
  logic signed [15:0] mem [4][4];
  int                 rd_count = 0;
  int                 pass_cnt = 0;
  int                 total_cnt = 0;

  int run_cycles, run_first_rd, run_busy_first, run_busy_mid;
  int run_hold_bad, run_stall_bad;
  bit run_aborted, run_timed_out;

  // Memory model returns data exactly one cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_row][bus.rd_col];
  end

  always @(negedge clk) begin
    if (bus.pool_valid && bus.pool_ready)
      results.push_back('{int'($signed(bus.pool_data)), int'(bus.pool_row), int'(bus.pool_col)});
    if (bus.rd_en) rd_count++;
  end

  function automatic int outVec();
    return int'({bus.rd_en, bus.rd_row, bus.rd_col, bus.pool_valid, bus.pool_data,
                 bus.pool_row, bus.pool_col, busy, done});
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic loadMap(input int kind);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        int v;
        v = r * 4 + c;
        case (kind)
          1:       v = v - 16;
          2:       v = 15 - v;
          3:       v = (c % 2 == 1) ? -v : v;
          default: v = v;
        endcase
        mem[r][c] = 16'(v);
      end
    end
  endtask

  // mode 0 plain, 1 ready held low 5 cycles per result, 2 writer stall in window 1,
  // 3 extra start while busy, 4 stop as soon as window 2 starts reading.
  task automatic applyStimulus(input int mode);
    int   hold_cnt;
    int   stall_cnt;
    int   held;
    bit   finished;
    hold_cnt = 0;
    stall_cnt = 0;
    held = 0;
    finished = 1'b0;
    run_first_rd = 0;
    run_busy_first = 0;
    run_busy_mid = 0;
    run_hold_bad = 0;
    run_stall_bad = 0;
    run_aborted = 1'b0;
    bus.pool_ready = (mode == 1) ? 1'b0 : 1'b1;
    start = 1'b1;
    run_cycles = 1;
    while (!finished && run_cycles < 400) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      run_cycles++;
      if (run_cycles == 2) begin
        run_first_rd = int'({bus.rd_en, bus.rd_row, bus.rd_col});
        run_busy_first = int'(busy);
      end
      case (mode)
        1: begin
          if (bus.pool_valid) begin
            hold_cnt++;
            if (hold_cnt == 1) held = int'({bus.pool_data, bus.pool_row, bus.pool_col});
            else if (int'({bus.pool_data, bus.pool_row, bus.pool_col}) != held) run_hold_bad++;
            if (hold_cnt >= 6) bus.pool_ready = 1'b1;
          end else begin
            hold_cnt = 0;
            bus.pool_ready = 1'b0;
          end
        end
        2: begin
          if (stall_cnt == 0 && bus.rd_en && bus.rd_row == 2'd0 && bus.rd_col == 2'd3) begin
            cv_write_en = 1'b1;
            stall_cnt = 1;
          end else if (stall_cnt >= 1 && stall_cnt < 3) begin
            stall_cnt++;
          end else if (stall_cnt == 3) begin
            cv_write_en = 1'b0;
            stall_cnt = 4;
          end
          if (cv_write_en) begin
            #1;
            if (bus.rd_en !== 1'b0 || bus.rd_row !== 2'd0 || bus.rd_col !== 2'd3) run_stall_bad++;
          end
        end
        3: begin
          if (run_cycles == 10) start = 1'b1;
          if (run_cycles == 11) run_busy_mid = int'(busy);
        end
        4: begin
          if (bus.rd_en && bus.pool_row == 1'b1 && bus.pool_col == 1'b0) begin
            run_aborted = 1'b1;
            finished = 1'b1;
          end
        end
        default: ;
      endcase
      if (done) finished = 1'b1;
    end
    if (mode == 2 && stall_cnt != 4) run_stall_bad++;
    run_timed_out = !finished;
  endtask

  task automatic checkResults(input string tag, input int kind, input int base);
    checkOutput({tag, "_count"}, results.size() - base, 4);
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].kind == kind) begin
        res_t r;
        r = '{-99999, -1, -1};
        if (base + vecs[i].widx < results.size()) r = results[base + vecs[i].widx];
        checkOutput($sformatf("%s_w%0d_data", tag, vecs[i].widx), r.data, vecs[i].exp_data);
        checkOutput($sformatf("%s_w%0d_row", tag, vecs[i].widx), r.row, vecs[i].exp_row);
        checkOutput($sformatf("%s_w%0d_col", tag, vecs[i].widx), r.col, vecs[i].exp_col);
      end
    end
  endtask

  initial begin
    int exp_tab [4][4];
    int base;
    int rd0;
    int done_seen;

    // Maps: 0 ascending, 1 ascending minus 16, 2 descending, 3 odd columns negated.
    exp_tab = '{'{5, 7, 13, 15}, '{-11, -9, -3, -1}, '{15, 13, 7, 5}, '{4, 6, 12, 14}};
    for (int k = 0; k < 4; k++)
      for (int w = 0; w < 4; w++)
        vecs[k * 4 + w] = '{k, w, exp_tab[k][w], w / 2, w % 2};

    bus.pool_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_outputs", outVec(), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < 4; k++) begin
      loadMap(k);
      base = results.size();
      rd0 = rd_count;
      applyStimulus(0);
      checkOutput($sformatf("map%0d_timeout", k), int'(run_timed_out), 0);
      checkOutput($sformatf("map%0d_cycles", k), run_cycles, 26);
      checkOutput($sformatf("map%0d_reads", k), rd_count - rd0, 16);
      if (k == 0) begin
        checkOutput("first_rd_addr", run_first_rd, 16);
        checkOutput("busy_after_start", run_busy_first, 1);
      end
      checkResults($sformatf("map%0d", k), k, base);
      @(posedge clk);
      #1;
      checkOutput($sformatf("map%0d_busy_cleared", k), int'(busy), 0);
    end

    loadMap(0);
    base = results.size();
    rd0 = rd_count;
    applyStimulus(1);
    checkOutput("hold_timeout", int'(run_timed_out), 0);
    checkOutput("hold_cycles", run_cycles, 46);
    checkOutput("hold_stable", run_hold_bad, 0);
    checkOutput("hold_reads", rd_count - rd0, 16);
    checkResults("hold", 0, base);
    bus.pool_ready = 1'b1;
    @(posedge clk);
    #1;

    base = results.size();
    rd0 = rd_count;
    applyStimulus(2);
    checkOutput("stall_timeout", int'(run_timed_out), 0);
    checkOutput("stall_cycles", run_cycles, 29);
    checkOutput("stall_frozen", run_stall_bad, 0);
    checkOutput("stall_reads", rd_count - rd0, 16);
    checkResults("stall", 0, base);
    @(posedge clk);
    #1;

    base = results.size();
    rd0 = rd_count;
    applyStimulus(3);
    checkOutput("restart_timeout", int'(run_timed_out), 0);
    checkOutput("restart_cycles", run_cycles, 26);
    checkOutput("restart_busy_mid", run_busy_mid, 1);
    checkResults("restart", 0, base);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("restart_not_queued_busy", int'(busy), 0);
    checkOutput("restart_not_queued_reads", rd_count - rd0, 16);

    rd0 = rd_count;
    cv_write_en = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("wr_start_busy", int'(busy), 0);
    checkOutput("wr_start_rd_en", int'(bus.rd_en), 0);
    cv_write_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("wr_start_not_queued_busy", int'(busy), 0);
    checkOutput("wr_start_not_queued_reads", rd_count - rd0, 0);

    applyStimulus(4);
    checkOutput("abort_reached_window2", int'(run_aborted), 1);
    reset = 1'b0;
    #1;
    checkOutput("abort_outputs_async", outVec(), 0);
    done_seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    checkOutput("abort_outputs_held", outVec(), 0);
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    checkOutput("abort_no_done", done_seen, 0);
    checkOutput("abort_idle_busy", int'(busy), 0);

    base = results.size();
    rd0 = rd_count;
    applyStimulus(0);
    checkOutput("fresh_timeout", int'(run_timed_out), 0);
    checkOutput("fresh_cycles", run_cycles, 26);
    checkOutput("fresh_reads", rd_count - rd0, 16);
    checkResults("fresh", 0, base);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
